// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, port ids and counter width for dmem_arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;
    localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant, ties go to the port that did not win last
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);
    assign grant_valid = req0 | req1;
    assign grant = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/ack data-memory arbiter with fixed access latency (optional DMEM_ARB_ALIGN_CHECK_EN misalignment errors)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    output logic                  ack0_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic                  err0_o,
    output logic                  stall0_o,
    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  err1_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  busy_o
);
    state_t                state, state_nx;
    logic                  last_grant, port, we, grant, grant_valid, bad, access, last_acc, take;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata, rdata0, rdata1, rdata_nx;

    rr_arb2 u_arb (
        .req0        (req0_i),
        .req1        (req1_i),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign bad = addr[1:0] != 2'b00;
`else
    assign bad = 1'b0;
`endif

    assign access   = state == ACCESS;
    assign last_acc = access && cnt == '0;
    assign take     = state == IDLE && grant_valid;
    assign rdata_nx = (we | bad) ? '0 : mem_data_i;

    always_comb begin
        state_nx = state;
        if (take) state_nx = ACCESS;
        else if (last_acc) state_nx = RESP;
        else if (state == RESP) state_nx = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            last_grant <= PORT_AUX;
            port       <= PORT_CPU;
            cnt        <= '0;
            we         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                port       <= grant;
                last_grant <= grant;
                cnt        <= CNT_W'(LATENCY - 1);
                we         <= grant ? we1_i : we0_i;
                addr       <= grant ? addr1_i : addr0_i;
                wdata      <= grant ? wdata1_i : wdata0_i;
            end else if (access) begin
                cnt <= cnt - 1'b1;
            end
            if (last_acc && port == PORT_CPU) rdata0 <= rdata_nx;
            if (last_acc && port == PORT_AUX) rdata1 <= rdata_nx;
        end
    end

    assign mem_addr_o  = access ? addr : '0;
    assign mem_data_o  = access ? wdata : '0;
    assign mem_read_o  = access & ~we & ~bad;
    assign mem_write_o = last_acc & we & ~bad;
    assign ack0_o      = state == RESP && port == PORT_CPU;
    assign ack1_o      = state == RESP && port == PORT_AUX;
    assign err0_o      = ack0_o & bad;
    assign err1_o      = ack1_o & bad;
    assign rdata0_o    = rdata0;
    assign rdata1_o    = rdata1;
    assign stall0_o    = req0_i & ~ack0_o;
    assign busy_o      = state != IDLE;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port byte-addressed data memory between two requesters: port 0 (CPU MEM stage) and port 1 (DMA/debug loader). Uses a req/ack handshake with a programmable access latency, so the CPU sees a stall instead of an instant access. Sits between the pipeline's MEM stage and the data memory and drives that memory's address, write data and MemRead/MemWrite strobes.

Parameters:
LATENCY, 2, ACCESS-state cycles per transaction (legal range 1..15).
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, word width.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
req0_i  in  1  port 0 request
we0_i  in  1  port 0 write enable (0 = read)
addr0_i  in  ADDR_WIDTH  port 0 byte address
wdata0_i  in  DATA_WIDTH  port 0 write data
ack0_o  out  1  port 0 completion pulse
rdata0_o  out  DATA_WIDTH  port 0 read data, valid with ack0_o
err0_o  out  1  port 0 misalignment error, valid with ack0_o
stall0_o  out  1  req0_i & ~ack0_o (combinational; CPU stall)
req1_i, we1_i, addr1_i, wdata1_i, ack1_o, rdata1_o, err1_o  as port 0
mem_addr_o  out  ADDR_WIDTH  to memory addr_i
mem_data_o  out  DATA_WIDTH  to memory data_i
mem_read_o  out  1  to memory MemRead_i
mem_write_o  out  1  to memory MemWrite_i
mem_data_i  in  DATA_WIDTH  from memory data_o (combinational read)
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, last_grant=1, counter 0, all outputs 0. Any in-flight transaction is aborted; if reset asserts before the final ACCESS edge, no write occurs.
- States: IDLE, ACCESS, RESP.
- IDLE arbitration:
  - Only one req: grant it.
  - Both reqs: grant the port != last_grant (round-robin, so port 0 wins the first tie).
  - On the grant edge: latch we/addr/wdata and the port id, update last_grant, counter <= LATENCY-1, go to ACCESS.
- ACCESS:
  - mem_addr_o/mem_data_o drive the latched values; mem_read_o = ~we for every ACCESS cycle.
  - mem_write_o = we only in the final ACCESS cycle (counter==0), so memory is written exactly once.
  - Counter decrements each cycle. At counter==0, capture mem_data_i into the read-data register (0 for writes) and go to RESP.
- RESP: ack of the granted port high for exactly 1 cycle, with rdata/err valid; other port's outputs 0. Next state IDLE.
- Timing: req sampled in cycle 0 gives ack in cycle LATENCY+1 (cycle 3 at the default). Minimum spacing between acks is LATENCY+2 cycles.
- Handshake:
  - Requester holds req and its payload until it sees ack; payload changes after the grant are ignored.
  - req still high in the cycle after ack is a new request.
  - Dropping req before ack is illegal, but the arbiter still completes the transaction and pulses ack.
- The losing requester waits in IDLE arbitration; no starvation (worst-case wait is one transaction).
- rdataN_o holds its value until that port's next ack. mem_* outputs are 0 outside ACCESS.

Optional Feature:
DMEM_ARB_ALIGN_CHECK_EN
- Defined: a latched addr[1:0]!=0 gives no memory strobes during ACCESS. The latency is still counted, then RESP pulses ack with err=1 and rdata=0.
- Undefined: no check; addresses pass unmodified; errN_o tied 0.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - port ids (PORT_CPU=1'b0, PORT_AUX=1'b1)
  - counter width constant (4)
- Sub-module rr_arb2: 2-input round-robin grant logic (req0, req1, last_grant -> grant, grant_valid), instantiated once.

Test Plan:
1. Memory preloaded with 32'hDEADBEEF at byte address 4. req0 read addr 4 at cycle 0 -> ack0_o high in cycle 3 only; rdata0_o=32'hDEADBEEF; stall0_o high in cycles 0-2; mem_write_o never high.
2. req0 write 32'h12345678 to addr 8, then read addr 8 -> mem_write_o high exactly 1 cycle (cycle 2); the read returns 32'h12345678 with bytes in little-endian order in memory[8..11].
3. req0 and req1 raised together and held -> grants alternate 0,1,0,1; acks 4 cycles apart; each port acked every 8 cycles.
4. req1 only, held continuously for 3 transactions -> 3 acks at cycles 3, 7, 11; port 0 stall0_o stays 0.
5. Write 32'hCAFEF00D to addr 12 with rst_i pulsed low during the first ACCESS cycle -> all outputs 0 immediately, memory[12..15] unchanged, busy_o=0 after reset.
6. With DMEM_ARB_ALIGN_CHECK_EN, read addr 6 -> ack0_o at cycle 3 with err0_o=1, rdata0_o=0, mem_read_o never high. Without the macro -> normal access, err0_o=0.
